// File: rtl/cpu_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
// Holds the arbiter state encoding, default bus width and wait-counter width.
package cpu_pkg;

    localparam int DEF_BUS_WIDTH = 16;
    localparam int WAIT_CNT_W    = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CPU_RD = 2'd1,
        S_DBG_RD = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_wait_cnt.sv
// Saturating count of cycles a pending debug request has lost arbitration.
// Latency: sat is registered, valid the cycle after the losing cycle.
// Backpressure: none; inc/clr are sampled every cycle, clr dominates.
module arb_wait_cnt
    import cpu_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    logic [WAIT_CNT_W-1:0] cnt;

    assign sat = (cnt == WAIT_CNT_W'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port sync-read data memory between CPU and debug port.
// Latency: one access issued per cycle, read data returns the next cycle.
// Backpressure: CPU held via cpu_stall; debug waits for dbg_gnt (bounded by MAX_WAIT).
module dmem_arbiter
    import cpu_pkg::*;
#(
    parameter int BUS_WIDTH = DEF_BUS_WIDTH,
    parameter int MAX_WAIT  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [BUS_WIDTH-1:0] cpu_addr,
    input  logic [BUS_WIDTH-1:0] cpu_wdata,
    output logic [BUS_WIDTH-1:0] cpu_rdata,
    output logic                 cpu_stall,
    input  logic                 dbg_req,
    input  logic                 dbg_we,
    input  logic [BUS_WIDTH-1:0] dbg_addr,
    input  logic [BUS_WIDTH-1:0] dbg_wdata,
    output logic                 dbg_gnt,
    output logic                 dbg_rvalid,
    output logic [BUS_WIDTH-1:0] dbg_rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [BUS_WIDTH-1:0] mem_addr,
    output logic [BUS_WIDTH-1:0] mem_wdata,
    input  logic [BUS_WIDTH-1:0] mem_rdata
);

    arb_state_t state, state_nxt;
    logic       wait_sat;
    logic       dbg_win, cpu_win;

    // Debug only beats a live CPU request once it has waited MAX_WAIT cycles.
    assign dbg_win = (state == S_IDLE) && dbg_req && (!cpu_req || wait_sat);
    assign cpu_win = (state == S_IDLE) && !dbg_win && cpu_req;

    arb_wait_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (dbg_req && !dbg_win),
        .clr   (!dbg_req || dbg_win),
        .sat   (wait_sat)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = S_IDLE;
        if (dbg_win && !dbg_we) begin
            state_nxt = S_DBG_RD;
        end else if (cpu_win && !cpu_we) begin
            state_nxt = S_CPU_RD;
        end
    end

    // Every output is held at zero while reset is asserted.
    always_comb begin
        cpu_rdata  = '0;
        cpu_stall  = 1'b0;
        dbg_gnt    = 1'b0;
        dbg_rvalid = 1'b0;
        dbg_rdata  = '0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (reset) begin
            unique case (state)
                S_IDLE: begin
                    if (dbg_win) begin
                        dbg_gnt   = 1'b1;
                        cpu_stall = cpu_req;
                        mem_en    = 1'b1;
                        mem_we    = dbg_we;
                        mem_addr  = dbg_addr;
                        mem_wdata = dbg_wdata;
                    end else if (cpu_win) begin
                        cpu_stall = !cpu_we;
                        mem_en    = 1'b1;
                        mem_we    = cpu_we;
                        mem_addr  = cpu_addr;
                        mem_wdata = cpu_wdata;
                    end
                end
                S_CPU_RD: begin
                    cpu_rdata = mem_rdata;
                end
                S_DBG_RD: begin
                    dbg_rvalid = 1'b1;
                    dbg_rdata  = mem_rdata;
                    cpu_stall  = cpu_req;
                end
                default: begin
                    cpu_stall = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous-read memory.
// Inputs change and outputs are sampled around the falling clock edge.
module tb_dmem_arbiter;

    localparam int BW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [BW-1:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic          cpu_stall;
    logic          dbg_req, dbg_we;
    logic [BW-1:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic          dbg_gnt, dbg_rvalid;
    logic          mem_en, mem_we;
    logic [BW-1:0] mem_addr, mem_wdata, mem_rdata;

    logic [BW-1:0] mem [0:255];

    int n_cmp = 0;
    int n_err = 0;

    dmem_arbiter #(.BUS_WIDTH(BW), .MAX_WAIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model; preload happens while reset is low, when the arbiter issues nothing.
    always @(posedge clk) begin
        if (!reset) begin
            mem[8'h20] <= 16'h1234;
            mem[8'h30] <= 16'h5A5A;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic c_req, input logic c_we,
                         input logic [BW-1:0] c_addr, input logic [BW-1:0] c_wd,
                         input logic d_req, input logic d_we,
                         input logic [BW-1:0] d_addr, input logic [BW-1:0] d_wd);
        @(negedge clk);
        reset     = rst;
        cpu_req   = c_req;
        cpu_we    = c_we;
        cpu_addr  = c_addr;
        cpu_wdata = c_wd;
        dbg_req   = d_req;
        dbg_we    = d_we;
        dbg_addr  = d_addr;
        dbg_wdata = d_wd;
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".stall"},  cpu_stall,  0);
        check({tag, ".gnt"},    dbg_gnt,    0);
        check({tag, ".rvalid"}, dbg_rvalid, 0);
        check({tag, ".en"},     mem_en,     0);
        check({tag, ".we"},     mem_we,     0);
        check({tag, ".addr"},   mem_addr,   0);
        check({tag, ".wdata"},  mem_wdata,  0);
        check({tag, ".crd"},    cpu_rdata,  0);
        check({tag, ".drd"},    dbg_rdata,  0);
    endtask

    initial begin
        mem_rdata = '0;
        // Reset with both requesters asserting.
        drive(0, 1, 1, 16'h0010, 16'hBEEF, 1, 0, 16'h0077, 16'h7777);
        check_all_zero("rst0");
        drive(0, 1, 1, 16'h0010, 16'hBEEF, 1, 0, 16'h0077, 16'h7777);
        check_all_zero("rst1");

        // First cycle after release: CPU write issues with no stall.
        drive(1, 1, 1, 16'h0010, 16'hBEEF, 0, 0, 16'h0000, 16'h0000);
        check("wr.en", mem_en, 1);
        check("wr.we", mem_we, 1);
        check("wr.addr", mem_addr, 16'h0010);
        check("wr.wdata", mem_wdata, 16'hBEEF);
        check("wr.stall", cpu_stall, 0);

        // CPU read of 0x0020: one stall cycle then data.
        drive(1, 1, 0, 16'h0020, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        check("rd.en", mem_en, 1);
        check("rd.we", mem_we, 0);
        check("rd.addr", mem_addr, 16'h0020);
        check("rd.stall", cpu_stall, 1);
        check("wr.mem", mem[8'h10], 16'hBEEF);
        drive(1, 1, 0, 16'h0020, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        check("rd.data", cpu_rdata, 16'h1234);
        check("rd.stall2", cpu_stall, 0);
        check("rd.noreissue", mem_en, 0);
        drive(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        check("rd.idle", mem_en, 0);

        // Debug-only write 0x00FF to 0x0003, then read it back.
        drive(1, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0003, 16'h00FF);
        check("dw.gnt", dbg_gnt, 1);
        check("dw.we", mem_we, 1);
        check("dw.addr", mem_addr, 16'h0003);
        check("dw.stall", cpu_stall, 0);
        drive(1, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0003, 16'h0000);
        check("dr.gnt", dbg_gnt, 1);
        check("dr.we", mem_we, 0);
        check("dr.rv0", dbg_rvalid, 0);
        drive(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        check("dr.rvalid", dbg_rvalid, 1);
        check("dr.rdata", dbg_rdata, 16'h00FF);
        check("dr.en", mem_en, 0);
        drive(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        check("dr.rv_end", dbg_rvalid, 0);

        // Back-to-back CPU writes with debug write pending: grant in 5th cycle.
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 1, 16'h0040 + 16'(i), 16'h0100 + 16'(i), 1, 1, 16'h0050, 16'hAAAA);
            check($sformatf("st%0d.gnt", i), dbg_gnt, (i == 4) ? 1 : 0);
            check($sformatf("st%0d.stall", i), cpu_stall, (i == 4) ? 1 : 0);
            check($sformatf("st%0d.addr", i), mem_addr, (i == 4) ? 16'h0050 : 16'h0040 + 16'(i));
        end
        drive(1, 1, 1, 16'h0044, 16'h0104, 0, 0, 16'h0000, 16'h0000);
        check("st5.gnt", dbg_gnt, 0);
        check("st5.stall", cpu_stall, 0);
        check("st5.addr", mem_addr, 16'h0044);

        // Debug read forced over a pending CPU read.
        drive(1, 1, 0, 16'h0020, 16'h0000, 1, 0, 16'h0050, 16'h0000);
        check("fr0.addr", mem_addr, 16'h0020);
        check("fr0.gnt", dbg_gnt, 0);
        drive(1, 1, 0, 16'h0020, 16'h0000, 1, 0, 16'h0050, 16'h0000);
        check("fr1.crd", cpu_rdata, 16'h1234);
        drive(1, 1, 0, 16'h0010, 16'h0000, 1, 0, 16'h0050, 16'h0000);
        check("fr2.addr", mem_addr, 16'h0010);
        drive(1, 1, 0, 16'h0010, 16'h0000, 1, 0, 16'h0050, 16'h0000);
        check("fr3.crd", cpu_rdata, 16'hBEEF);
        drive(1, 1, 0, 16'h0030, 16'h0000, 1, 0, 16'h0050, 16'h0000);
        check("fr4.gnt", dbg_gnt, 1);
        check("fr4.addr", mem_addr, 16'h0050);
        check("fr4.stall", cpu_stall, 1);
        drive(1, 1, 0, 16'h0030, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        check("fr5.rvalid", dbg_rvalid, 1);
        check("fr5.rdata", dbg_rdata, 16'hAAAA);
        check("fr5.stall", cpu_stall, 1);
        check("fr5.en", mem_en, 0);
        drive(1, 1, 0, 16'h0030, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        check("fr6.addr", mem_addr, 16'h0030);
        check("fr6.en", mem_en, 1);
        check("fr6.stall", cpu_stall, 1);
        drive(1, 1, 0, 16'h0030, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        check("fr7.crd", cpu_rdata, 16'h5A5A);
        check("fr7.stall", cpu_stall, 0);
        check("fr7.nodup", mem_en, 0);

        // Reset asserted while a debug read is returning.
        drive(1, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0050, 16'h0000);
        check("rr.gnt", dbg_gnt, 1);
        drive(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0050, 16'h0000);
        check("rr.rv_in_rst", dbg_rvalid, 0);
        drive(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        check("rr.rv_after", dbg_rvalid, 0);
        check("rr.en", mem_en, 0);
        check("rr.state", dut.state, 0);
        check("rr.cnt", dut.u_wait_cnt.cnt, 0);
        drive(1, 1, 1, 16'h0060, 16'h0006, 1, 1, 16'h0061, 16'h0007);
        check("rr.cpu_first", dbg_gnt, 0);
        check("rr.cpu_addr", mem_addr, 16'h0060);
        drive(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
